// File: rtl/return_addr_stack_pkg.sv
// Shared fetch front-end definitions: default widths, jump opcodes and the
// per-cycle operation decode used by the return-address stack.
package return_addr_stack_pkg;

    localparam int unsigned ADDRESS_WIDTH_DEF = 22;
    localparam int unsigned RAS_DEPTH_DEF     = 8;

    // Jump encodings shared with the pre-aligner and fetch.
    localparam logic [5:0] OPC_J    = 6'h02;
    localparam logic [5:0] OPC_JAL  = 6'h03;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    typedef enum logic [1:0] {
        RAS_IDLE = 2'd0,
        RAS_PUSH = 2'd1,
        RAS_POP  = 2'd2,
        RAS_SWAP = 2'd3
    } ras_op_e;

    function automatic ras_op_e ras_decode(input logic jal, input logic jr);
        case ({jal, jr})
            2'b10:   return RAS_PUSH;
            2'b01:   return RAS_POP;
            2'b11:   return RAS_SWAP;
            default: return RAS_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/return_addr_stack_mem.sv
// Return-address storage: DEPTH x ADDRESS_WIDTH register file with one
// synchronous write port and one asynchronous read port; contents not reset.
module ras_mem #(
    parameter int unsigned ADDRESS_WIDTH = 22,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned PTR_WIDTH     = 3
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [PTR_WIDTH-1:0]     waddr,
    input  logic [ADDRESS_WIDTH-1:0] wdata,
    input  logic [PTR_WIDTH-1:0]     raddr,
    output logic [ADDRESS_WIDTH-1:0] rdata
);

    logic [ADDRESS_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// Circular return-address stack: jal pushes address+1, jr pops the predicted
// return target one cycle later; overflow overwrites the oldest entry.
module return_addr_stack
    import return_addr_stack_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int unsigned DEPTH         = RAS_DEPTH_DEF
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_Stall,
    input  logic                     i_Flush,
    input  logic                     i_jal_inst,
    input  logic                     i_jr_inst,
    input  logic [ADDRESS_WIDTH-1:0] i_branch_address,
    output logic [ADDRESS_WIDTH-1:0] o_Return_Target,
    output logic                     o_ret_valid,
    output logic                     o_underflow,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

    logic [PTR_WIDTH-1:0]     tos_q, tos_d;
    logic [CNT_WIDTH-1:0]     count_q, count_d;
    logic [ADDRESS_WIDTH-1:0] target_q, target_d;
    logic                     ret_valid_q, ret_valid_d;
    logic                     underflow_q, underflow_d;

    logic                     mem_we;
    logic [PTR_WIDTH-1:0]     mem_waddr;
    logic [ADDRESS_WIDTH-1:0] mem_wdata;
    logic [ADDRESS_WIDTH-1:0] mem_rdata;
    ras_op_e                  op;

    ras_mem #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DEPTH         (DEPTH),
        .PTR_WIDTH     (PTR_WIDTH)
    ) u_mem (
        .clk   (i_Clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (tos_q),
        .rdata (mem_rdata)
    );

    assign op        = ras_decode(i_jal_inst, i_jr_inst);
    assign mem_wdata = i_branch_address + ADDRESS_WIDTH'(1);

    always_comb begin
        tos_d       = tos_q;
        count_d     = count_q;
        target_d    = target_q;
        ret_valid_d = ret_valid_q;
        underflow_d = underflow_q;
        mem_we      = 1'b0;
        mem_waddr   = tos_q;

        if (i_Flush) begin
            tos_d       = '0;
            count_d     = '0;
            ret_valid_d = 1'b0;
            underflow_d = 1'b0;
        end else if (!i_Stall) begin
            ret_valid_d = 1'b0;
            underflow_d = 1'b0;
            case (op)
                RAS_PUSH: begin
                    tos_d     = tos_q + PTR_WIDTH'(1);
                    mem_waddr = tos_q + PTR_WIDTH'(1);
                    mem_we    = 1'b1;
                    if (count_q != CNT_FULL) begin
                        count_d = count_q + CNT_WIDTH'(1);
                    end
                end
                RAS_POP, RAS_SWAP: begin
                    if (count_q != '0) begin
                        target_d    = mem_rdata;
                        ret_valid_d = 1'b1;
                    end else begin
                        target_d    = '0;
                        underflow_d = 1'b1;
                    end
                    // Swap reads the old top and rewrites the same slot in one
                    // edge; the async read sees the pre-edge contents.
                    if (op == RAS_SWAP) begin
                        mem_we = 1'b1;
                        if (count_q == '0) begin
                            count_d = CNT_WIDTH'(1);
                        end
                    end else if (count_q != '0) begin
                        tos_d   = tos_q - PTR_WIDTH'(1);
                        count_d = count_q - CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            tos_q       <= '0;
            count_q     <= '0;
            target_q    <= '0;
            ret_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            tos_q       <= tos_d;
            count_q     <= count_d;
            target_q    <= target_d;
            ret_valid_q <= ret_valid_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_Return_Target = target_q;
    assign o_ret_valid     = ret_valid_q;
    assign o_underflow     = underflow_q;
    assign o_empty         = (count_q == '0);
    assign o_full          = (count_q == CNT_FULL);

endmodule

// File: tb/tb_return_addr_stack.sv
// Bench for return_addr_stack: vector table plus hand sequences, checked
// through an expected-result queue one cycle after each drive.
module tb_return_addr_stack;

    localparam int unsigned AW = 22;

    typedef struct {
        logic          stall;
        logic          flush;
        logic          jal;
        logic          jr;
        logic [AW-1:0] addr;
        logic [AW-1:0] e_tgt;
        logic          e_val;
        logic          e_uf;
        logic          e_empty;
        logic          e_full;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, flush, jal, jr;
    logic [AW-1:0] addr;
    logic [AW-1:0] tgt;
    logic          ret_valid, underflow, empty, full;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_steps  = 0;
    vec_t sb[$];
    vec_t tbl[$];
    vec_t exp_r;

    always #5 clk = ~clk;

    return_addr_stack #(
        .ADDRESS_WIDTH (AW),
        .DEPTH         (8)
    ) dut (
        .i_Clk            (clk),
        .i_Reset          (rst),
        .i_Stall          (stall),
        .i_Flush          (flush),
        .i_jal_inst       (jal),
        .i_jr_inst        (jr),
        .i_branch_address (addr),
        .o_Return_Target  (tgt),
        .o_ret_valid      (ret_valid),
        .o_underflow      (underflow),
        .o_empty          (empty),
        .o_full           (full)
    );

    function automatic vec_t mk(input logic s, input logic f, input logic jl, input logic jrr,
                                input logic [AW-1:0] a, input logic [AW-1:0] t,
                                input logic v, input logic u, input logic e, input logic fu);
        vec_t r;
        r.stall = s; r.flush = f; r.jal = jl; r.jr = jrr; r.addr = a;
        r.e_tgt = t; r.e_val = v; r.e_uf = u; r.e_empty = e; r.e_full = fu;
        return r;
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, id, got, want);
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        stall = v.stall; flush = v.flush; jal = v.jal; jr = v.jr; addr = v.addr;
        sb.push_back(v);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_r = sb.pop_front();
            n_steps++;
            chk("target",    n_steps, 32'(tgt),       32'(exp_r.e_tgt));
            chk("ret_valid", n_steps, 32'(ret_valid), 32'(exp_r.e_val));
            chk("underflow", n_steps, 32'(underflow), 32'(exp_r.e_uf));
            chk("empty",     n_steps, 32'(empty),     32'(exp_r.e_empty));
            chk("full",      n_steps, 32'(full),      32'(exp_r.e_full));
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; jal = 1'b0; jr = 1'b0; addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_target", 0, 32'(tgt),       32'h0);
        chk("reset_valid",  0, 32'(ret_valid), 32'h0);
        chk("reset_uf",     0, 32'(underflow), 32'h0);
        chk("reset_empty",  0, 32'(empty),     32'h1);
        chk("reset_full",   0, 32'(full),      32'h0);
        @(negedge clk);
        rst = 1'b0;

        // basic push/pop and one-cycle valid
        tbl.push_back(mk(0,0,1,0,22'h000100, 22'h0,     0,0,0,0));
        tbl.push_back(mk(0,0,0,1,22'h000104, 22'h000101,1,0,1,0));
        tbl.push_back(mk(0,0,0,0,22'h0,      22'h000101,0,0,1,0));
        // LIFO then underflow
        tbl.push_back(mk(0,0,1,0,22'h10, 22'h101,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,22'h20, 22'h101,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,22'h30, 22'h101,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,22'h0,  22'h31, 1,0,0,0));
        tbl.push_back(mk(0,0,0,1,22'h0,  22'h21, 1,0,0,0));
        tbl.push_back(mk(0,0,0,1,22'h0,  22'h11, 1,0,1,0));
        tbl.push_back(mk(0,0,0,1,22'h0,  22'h0,  0,1,1,0));
        tbl.push_back(mk(0,0,0,0,22'h0,  22'h0,  0,0,1,0));
        // overflow: 9 pushes into 8 entries
        for (int i = 1; i <= 9; i++)
            tbl.push_back(mk(0,0,1,0,AW'(i), 22'h0,0,0,0,(i >= 8)));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0,0,0,1,22'h0, AW'(10 - k),1,0,(k == 7),0));
        tbl.push_back(mk(0,0,0,1,22'h0, 22'h0,0,1,1,0));
        // simultaneous jal+jr replaces top
        tbl.push_back(mk(0,0,1,0,22'h40, 22'h0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,1,22'h50, 22'h41,1,0,0,0));
        tbl.push_back(mk(0,0,0,1,22'h0,  22'h51,1,0,1,0));
        tbl.push_back(mk(0,0,0,0,22'h0,  22'h51,0,0,1,0));
        // address+1 wraps
        tbl.push_back(mk(0,0,1,0,22'h3FFFFF, 22'h51,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,22'h0,      22'h0, 1,0,1,0));
        // jal+jr on empty stack: underflow pulse but entry written
        tbl.push_back(mk(0,0,1,1,22'h70, 22'h0, 0,1,0,0));
        tbl.push_back(mk(0,0,0,1,22'h0,  22'h71,1,0,1,0));

        foreach (tbl[i]) step(tbl[i]);

        // stall blocks the pop for three cycles
        step(mk(0,0,1,0,22'h60, 22'h71,0,0,0,0));
        for (int i = 0; i < 3; i++)
            step(mk(1,0,0,1,22'h0, 22'h71,0,0,0,0));
        step(mk(0,0,0,1,22'h0, 22'h61,1,0,1,0));
        // stall stretches the underflow pulse
        step(mk(0,0,0,1,22'h0, 22'h0,0,1,1,0));
        step(mk(1,0,0,0,22'h0, 22'h0,0,1,1,0));
        step(mk(0,0,0,0,22'h0, 22'h0,0,0,1,0));
        // flush wins over stall
        step(mk(0,0,1,0,22'h1, 22'h0,0,0,0,0));
        step(mk(0,0,1,0,22'h2, 22'h0,0,0,0,0));
        step(mk(0,0,1,0,22'h3, 22'h0,0,0,0,0));
        step(mk(0,0,0,1,22'h0, 22'h4,1,0,0,0));
        step(mk(1,1,1,0,22'h9, 22'h4,0,0,1,0));
        step(mk(0,0,0,1,22'h0, 22'h0,0,1,1,0));
        // asynchronous reset mid-cycle
        step(mk(0,0,1,0,22'h80, 22'h0, 0,0,0,0));
        step(mk(0,0,0,1,22'h0,  22'h81,1,0,1,0));
        step(mk(0,0,1,0,22'h90, 22'h81,0,0,0,0));
        @(posedge clk);
        #3;
        jal = 1'b0; jr = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_target", 1000, 32'(tgt),       32'h0);
        chk("async_valid",  1000, 32'(ret_valid), 32'h0);
        chk("async_empty",  1000, 32'(empty),     32'h1);
        @(negedge clk);
        rst = 1'b0;
        step(mk(0,0,0,1,22'h0, 22'h0,0,1,1,0));
        step(mk(0,0,0,0,22'h0, 22'h0,0,0,1,0));

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        chk("queue_drained", 2000, 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
